// File: rtl/rtc_bus_arbiter.sv
// -----------------------------------------------------------------------------
// rtc_bus_arbiter
// Single owner of the shared RTC address/data bus. One of six sources (init,
// soft reset, time write, chrono program, chrono run, background read) holds
// the bus at a time. Ownership is a registered state. It changes only on a clock
// edge where frame_cnt marks the last cycle of an RTC frame. The bus outputs
// are a zero-latency mux of the owner's source buses.
//
// Ports
//   clk          in   system clock
//   reset        in   asynchronous, active-low reset
//   frame_cnt    in   [6:0] frame counter from the function generator
//   req_reset    in   soft-reset request (async level)
//   req_write    in   time-write request (async level)
//   req_crono    in   chrono-program request (async level)
//   req_cract    in   chrono-run request (async level)
//   addr_init    in   [7:0] init/soft-reset sequencer address
//   data_init    in   [7:0] init/soft-reset sequencer data
//   addr_read    in   [7:0] read sequencer address
//   addr_wr      in   [7:0] write-machine address (write, crono, cract)
//   data_wr      in   [7:0] write-machine data (write, crono, cract)
//   address      out  [7:0] bus address
//   data         out  [7:0] bus write data, 8'h00 when data_oe=0
//   data_oe      out  data valid/driven
//   ind_maquina  out  0 = write frame, 1 = read frame
//   grant        out  [5:0] one-hot {cract,crono,write,srst,init,read}
//   init_active  out  high while the init source owns the bus
// -----------------------------------------------------------------------------
module rtc_bus_arbiter #(
  parameter logic [6:0]  FRAME_END   = 7'h4A,
  parameter int unsigned INIT_CYCLES = 1034,
  parameter logic [7:0]  CRONO_ADDR  = 8'h00
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [6:0] frame_cnt,
  input  logic       req_reset,
  input  logic       req_write,
  input  logic       req_crono,
  input  logic       req_cract,
  input  logic [7:0] addr_init,
  input  logic [7:0] data_init,
  input  logic [7:0] addr_read,
  input  logic [7:0] addr_wr,
  input  logic [7:0] data_wr,
  output logic [7:0] address,
  output logic [7:0] data,
  output logic       data_oe,
  output logic       ind_maquina,
  output logic [5:0] grant,
  output logic       init_active
);

  typedef enum logic [2:0] {
    S_INIT  = 3'd0,
    S_SRST  = 3'd1,
    S_WRITE = 3'd2,
    S_CRONO = 3'd3,
    S_CRACT = 3'd4,
    S_READ  = 3'd5
  } state_t;

  localparam int unsigned      CNT_W    = $clog2(INIT_CYCLES);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(INIT_CYCLES - 1);

  // Request bit order inside the synchronizer: {cract, crono, write, reset}
  logic [3:0]       req_meta;
  logic [3:0]       req_sync;
  state_t           state;
  state_t           next_state;
  logic [CNT_W-1:0] init_cnt;
  logic             init_done;
  logic             boundary;

  assign boundary = (frame_cnt == FRAME_END);

  // Two-flop synchronizer for the asynchronous request switches
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      req_meta <= 4'b0000;
      req_sync <= 4'b0000;
    end else begin
      req_meta <= {req_cract, req_crono, req_write, req_reset};
      req_sync <= req_meta;
    end
  end

  // Next owner: held mid-frame, fixed-priority pick at the frame boundary
  always_comb begin
    next_state = state;
    case (state)
      S_INIT, S_SRST, S_WRITE, S_CRONO, S_CRACT, S_READ: begin
        if (boundary) begin
          if (!init_done)       next_state = S_INIT;
          else if (req_sync[0]) next_state = S_SRST;
          else if (req_sync[1]) next_state = S_WRITE;
          else if (req_sync[2]) next_state = S_CRONO;
          else if (req_sync[3]) next_state = S_CRACT;
          else                  next_state = S_READ;
        end else begin
          next_state = state;
        end
      end
      // Unused encodings fall back to a fresh init window
      default: next_state = S_INIT;
    endcase
  end

  // Owner register
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state <= S_INIT;
    end else begin
      state <= next_state;
    end
  end

  // Init window counter; entering soft reset re-arms the full window
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      init_cnt  <= '0;
      init_done <= 1'b0;
    end else if (boundary && (next_state == S_SRST)) begin
      init_cnt  <= '0;
      init_done <= 1'b0;
    end else if (state == S_INIT) begin
      if (init_cnt == CNT_LAST) begin
        init_done <= 1'b1;
      end else begin
        init_cnt <= init_cnt + {{(CNT_W-1){1'b0}}, 1'b1};
      end
    end else begin
      init_cnt  <= init_cnt;
      init_done <= init_done;
    end
  end

  // Bus mux decoded from the registered owner
  always_comb begin
    address     = addr_init;
    data        = data_init;
    data_oe     = 1'b1;
    ind_maquina = 1'b0;
    grant       = 6'b000010;
    init_active = 1'b0;
    case (state)
      S_INIT: begin
        init_active = 1'b1;
      end
      S_SRST: begin
        grant = 6'b000100;
      end
      S_WRITE: begin
        address = addr_wr;
        data    = data_wr;
        grant   = 6'b001000;
      end
      S_CRONO: begin
        // Chrono programming only writes at its single configuration address
        address = addr_wr;
        grant   = 6'b010000;
        if (addr_wr == CRONO_ADDR) begin
          data    = data_wr;
          data_oe = 1'b1;
        end else begin
          data    = 8'h00;
          data_oe = 1'b0;
        end
      end
      S_CRACT: begin
        address = addr_wr;
        data    = data_wr;
        grant   = 6'b100000;
      end
      S_READ: begin
        address     = addr_read;
        data        = 8'h00;
        data_oe     = 1'b0;
        ind_maquina = 1'b1;
        grant       = 6'b000001;
      end
      default: begin
        init_active = 1'b1;
      end
    endcase
  end

endmodule

// File: tb/tb_rtc_bus_arbiter.sv
// -----------------------------------------------------------------------------
// tb_rtc_bus_arbiter
// Bench for rtc_bus_arbiter. A reference model tracks who owns the bus. The
// model uses the owner index (0 read, 1 init, 2 srst, 3 write, 4 crono,
// 5 cract), which is also the grant bit position. It also tracks the number of
// clocks spent in the init window and a two-clock request delay. Directed
// scenarios use literal expectations, followed by a randomized run.
// -----------------------------------------------------------------------------
module tb_rtc_bus_arbiter;

  logic       clk = 1'b0;
  logic       reset;
  logic [6:0] frame_cnt;
  logic       req_reset, req_write, req_crono, req_cract;
  logic [7:0] addr_init, data_init, addr_read, addr_wr, data_wr;
  logic [7:0] address, data;
  logic       data_oe, ind_maquina, init_active;
  logic [5:0] grant;

  int checks   = 0;
  int failures = 0;
  bit hold_addr_wr = 1'b0;

  rtc_bus_arbiter dut (
    .clk(clk), .reset(reset), .frame_cnt(frame_cnt),
    .req_reset(req_reset), .req_write(req_write), .req_crono(req_crono), .req_cract(req_cract),
    .addr_init(addr_init), .data_init(data_init), .addr_read(addr_read),
    .addr_wr(addr_wr), .data_wr(data_wr),
    .address(address), .data(data), .data_oe(data_oe), .ind_maquina(ind_maquina),
    .grant(grant), .init_active(init_active)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [7:0] act, input logic [7:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h at t=%0t", name, act, exp, $time);
    end
  endtask

  // ---------------- reference model ----------------
  int         m_own;    // current owner index
  int         m_n;      // clocks spent in the init window since it was armed
  logic [3:0] m_d1, m_d2; // request delay line {cract,crono,write,reset}

  function automatic int pick(input int n, input logic [3:0] rq);
    if (n < 1034) return 1;
    if (rq[0])    return 2;
    if (rq[1])    return 3;
    if (rq[2])    return 4;
    if (rq[3])    return 5;
    return 0;
  endfunction

  always @(posedge clk or negedge reset) begin
    if (!reset) begin
      m_own <= 1;
      m_n   <= 0;
      m_d1  <= 4'b0000;
      m_d2  <= 4'b0000;
    end else begin
      m_d1 <= {req_cract, req_crono, req_write, req_reset};
      m_d2 <= m_d1;
      if (frame_cnt == 7'h4A) m_own <= pick(m_n, m_d2);
      if (frame_cnt == 7'h4A && pick(m_n, m_d2) == 2) m_n <= 0;
      else if (m_own == 1)                            m_n <= m_n + 1;
    end
  end

  // Compare every cycle on the falling edge
  always @(negedge clk) begin
    logic [7:0] ea, ed, eg;
    logic       eoe, eind;
    eg = 8'd1 << m_own;
    case (m_own)
      1, 2:    begin ea = addr_init; ed = data_init; eoe = 1'b1; eind = 1'b0; end
      3, 5:    begin ea = addr_wr;   ed = data_wr;   eoe = 1'b1; eind = 1'b0; end
      4: begin
        ea = addr_wr; eind = 1'b0;
        if (addr_wr == 8'h00) begin ed = data_wr; eoe = 1'b1; end
        else                  begin ed = 8'h00;   eoe = 1'b0; end
      end
      default: begin ea = addr_read; ed = 8'h00; eoe = 1'b0; eind = 1'b1; end
    endcase
    chk("m_grant",   {2'b00, grant}, eg);
    chk("m_address", address, ea);
    chk("m_data",    data, ed);
    chk("m_oe",      {7'd0, data_oe}, {7'd0, eoe});
    chk("m_ind",     {7'd0, ind_maquina}, {7'd0, eind});
    chk("m_init",    {7'd0, init_active}, {7'd0, (m_own == 1)});
    chk("m_onehot",  {7'd0, $onehot(grant)}, 8'd1);
  end

  // ---------------- stimulus helpers ----------------
  task automatic tick();
    @(posedge clk);
    #2;
    frame_cnt = (frame_cnt == 7'h4A) ? 7'h00 : frame_cnt + 7'd1;
    addr_init = 8'($urandom);
    data_init = 8'($urandom);
    addr_read = 8'($urandom);
    data_wr   = 8'($urandom);
    if (!hold_addr_wr) addr_wr = 8'($urandom);
  endtask

  task automatic wait_grant(input logic [5:0] g, input int bound, input string name, output int cyc);
    cyc = 0;
    while (grant !== g && cyc < bound) begin
      tick();
      cyc++;
    end
    chk(name, {2'b00, grant}, {2'b00, g});
  endtask

  task automatic wait_fc(input logic [6:0] v);
    int c;
    c = 0;
    while (frame_cnt != v && c < 200) begin
      tick();
      c++;
    end
    chk("wait_fc", {1'b0, frame_cnt}, {1'b0, v});
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int cyc;
    reset = 1'b0; frame_cnt = 7'h00;
    req_reset = 1'b0; req_write = 1'b0; req_crono = 1'b0; req_cract = 1'b0;
    addr_init = 8'h3C; data_init = 8'hA5; addr_read = 8'h41; addr_wr = 8'h12; data_wr = 8'h77;
    #1;
    chk("rst_grant", {2'b00, grant}, 8'h02);
    chk("rst_addr",  address, 8'h3C);
    chk("rst_data",  data, 8'hA5);
    chk("rst_oe",    {7'd0, data_oe}, 8'd1);
    chk("rst_ind",   {7'd0, ind_maquina}, 8'd0);
    chk("rst_initact", {7'd0, init_active}, 8'd1);
    repeat (3) tick();
    reset = 1'b1;

    // Power-up init window, then background read on a boundary
    wait_grant(6'b000001, 1300, "init_to_read", cyc);
    chk("init_len_min", {7'd0, (cyc >= 1034)}, 8'd1);
    chk("init_exit_fc", {1'b0, frame_cnt}, 8'h00);
    chk("read_ind", {7'd0, ind_maquina}, 8'd1);

    // Time write requested mid-frame
    wait_fc(7'd10);
    req_write = 1'b1;
    wait_grant(6'b001000, 200, "write_grant", cyc);
    chk("write_fc", {1'b0, frame_cnt}, 8'h00);
    #1;
    chk("write_addr", address, addr_wr);
    chk("write_data", data, data_wr);
    chk("write_oe", {7'd0, data_oe}, 8'd1);
    req_write = 1'b0;
    wait_grant(6'b000001, 200, "write_release", cyc);

    // Write beats crono; crono follows once write drops
    req_write = 1'b1; req_crono = 1'b1;
    wait_grant(6'b001000, 200, "prio_write", cyc);
    repeat (80) tick();
    chk("prio_write_hold", {2'b00, grant}, 8'h08);
    hold_addr_wr = 1'b1; addr_wr = 8'h00;
    req_write = 1'b0;
    wait_grant(6'b010000, 200, "crono_grant", cyc);
    #1;
    chk("crono_oe_at0", {7'd0, data_oe}, 8'd1);
    chk("crono_data_at0", data, data_wr);
    addr_wr = 8'h21;
    #1;
    chk("crono_oe_at21", {7'd0, data_oe}, 8'd0);
    chk("crono_data_at21", data, 8'h00);
    chk("crono_addr_at21", address, 8'h21);
    req_crono = 1'b0; hold_addr_wr = 1'b0;
    wait_grant(6'b000001, 200, "crono_release", cyc);

    // Soft reset re-runs the whole init window
    req_reset = 1'b1;
    wait_grant(6'b000100, 200, "srst_grant", cyc);
    #1;
    chk("srst_addr", address, addr_init);
    chk("srst_data", data, data_init);
    req_reset = 1'b0;
    wait_grant(6'b000010, 200, "srst_to_init", cyc);
    chk("srst_initact", {7'd0, init_active}, 8'd1);
    wait_grant(6'b000001, 1300, "srst_init_done", cyc);
    chk("srst_init_len", {7'd0, (cyc >= 1034)}, 8'd1);

    // Async reset in the middle of a chrono-run frame
    req_cract = 1'b1;
    wait_grant(6'b100000, 200, "cract_grant", cyc);
    req_cract = 1'b0;
    wait_fc(7'd30);
    reset = 1'b0;
    #1;
    chk("arst_grant", {2'b00, grant}, 8'h02);
    chk("arst_addr", address, addr_init);
    chk("arst_data", data, data_init);
    chk("arst_oe", {7'd0, data_oe}, 8'd1);
    chk("arst_ind", {7'd0, ind_maquina}, 8'd0);
    chk("arst_initact", {7'd0, init_active}, 8'd1);
    repeat (2) tick();
    reset = 1'b1;
    wait_grant(6'b000001, 1300, "arst_init_done", cyc);

    // Randomized requests and occasional async resets
    for (int i = 0; i < 20000; i++) begin
      tick();
      if ($urandom_range(0, 39) == 0) begin
        case ($urandom_range(0, 3))
          0: req_reset = ~req_reset;
          1: req_write = ~req_write;
          2: req_crono = ~req_crono;
          default: req_cract = ~req_cract;
        endcase
      end
      if ($urandom_range(0, 4999) == 0) begin
        reset = 1'b0;
        tick();
        reset = 1'b1;
      end
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
